dev_fsm: RTL and testbench



---
 rtl/dev_fsm.sv | 154 +++++++++++++++
 tb/tb_dev_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dev_fsm.sv
// -----------------------------------------------------------------------------
// dev_fsm: command-driven accumulator peripheral with a word-serial host port.
//
// The host selects the block with cs while it is idle. The word on din is then
// latched as a command, and zero, one or two operand words follow on the next
// consecutive cycles. The block adds the operands into an internal result
// register and can return the result on dout, marked by a one-cycle drdy strobe.
//
// Ports
//   clk   in   1   system clock, rising edge
//   rst   in   1   asynchronous, active-low reset
//   cs    in   1   chip select, sampled only in IDLE
//   din   in   DW  command or operand word
//   busy  out  1   high whenever the FSM is not in IDLE
//   dout  out  DW  last transmitted result, held between transmissions
//   drdy  out  1   one-cycle strobe marking a new value on dout
// -----------------------------------------------------------------------------

package cmd_bits;
    localparam int b_op_1   = 0;  // operand 1 follows
    localparam int b_op_2   = 1;  // operand 2 follows
    localparam int b_addop  = 2;  // result = op1 + op2
    localparam int b_addres = 3;  // result = result + op1
    localparam int b_tx     = 4;  // transmit the result
    localparam int b_clr    = 5;  // clear the result before the arithmetic
    localparam int CMD_W    = 6;  // bits at and above this index are reserved
endpackage

module dev_fsm #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [DW-1:0] din,
    output logic          busy,
    output logic [DW-1:0] dout,
    output logic          drdy
);
    import cmd_bits::*;

    generate
        if (DW < CMD_W) begin : g_dw_check
            $error("dev_fsm: DW must be at least 6 so every command bit fits");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP1,
        S_OP2,
        S_EXEC,
        S_TX
    } state_t;

    state_t              r_state;
    logic [CMD_W-1:0]    r_cmd;   // reserved command bits are never stored
    logic [DW-1:0]       r_op1;
    logic [DW-1:0]       r_op2;
    logic [DW-1:0]       r_res;
    logic [DW-1:0]       r_dout;
    logic                r_busy;
    logic                r_drdy;
    logic [DW-1:0]       w_res;

    // New result value for the latched command. Sums wrap modulo 2^DW, and
    // addop takes priority over addres. The clear only zeroes the accumulated
    // term, so with addop it has no visible effect.
    function automatic logic [DW-1:0] f_result(
        input logic [CMD_W-1:0] cmd,
        input logic [DW-1:0]    acc,
        input logic [DW-1:0]    op1,
        input logic [DW-1:0]    op2
    );
        logic [DW-1:0] base;
        base = cmd[b_clr] ? '0 : acc;
        if (cmd[b_addop])
            f_result = op1 + op2;
        else if (cmd[b_addres])
            f_result = base + op1;
        else
            f_result = base;
    endfunction

    assign w_res = f_result(r_cmd, r_res, r_op1, r_op2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cmd   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_res   <= '0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_drdy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cs) begin
                        r_cmd  <= din[CMD_W-1:0];
                        // Operands that are not sent read as zero.
                        r_op1  <= '0;
                        r_op2  <= '0;
                        r_busy <= 1'b1;
                        if (din[b_op_1])
                            r_state <= S_OP1;
                        else if (din[b_op_2])
                            r_state <= S_OP2;
                        else
                            r_state <= S_EXEC;
                    end
                end
                S_OP1: begin
                    r_op1 <= din;
                    if (r_cmd[b_op_2])
                        r_state <= S_OP2;
                    else
                        r_state <= S_EXEC;
                end
                S_OP2: begin
                    r_op2   <= din;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res <= w_res;
                    if (r_cmd[b_tx]) begin
                        r_dout  <= w_res;
                        r_drdy  <= 1'b1;
                        r_state <= S_TX;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_TX: begin
                    r_drdy  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_drdy  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign dout = r_dout;
    assign drdy = r_drdy;

endmodule

// File: tb/tb_dev_fsm.sv
// -----------------------------------------------------------------------------
// tb_dev_fsm: directed testbench for dev_fsm (DW = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dev_fsm;
    logic       clk;
    logic       rst;
    logic       cs;
    logic [7:0] din;
    logic       busy;
    logic [7:0] dout;
    logic       drdy;

    int checks   = 0;
    int failures = 0;

    // Results of the most recent run_txn call.
    int         t_drdy_cnt;
    int         t_drdy_idx;
    int         t_busy_fall;
    logic       t_first_busy;
    logic [7:0] t_dout;

    dev_fsm #(.DW(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .din  (din),
        .busy (busy),
        .dout (dout),
        .drdy (drdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one command and its n operand words. Sample index k means the
    // falling edge after edge C+k-1, where C is the edge that takes the command.
    task automatic run_txn(input logic [7:0] cmd, input int n,
                           input logic [7:0] o1, input logic [7:0] o2);
        @(negedge clk);
        cs  = 1'b1;
        din = cmd;
        t_drdy_cnt   = 0;
        t_drdy_idx   = -1;
        t_busy_fall  = -1;
        t_first_busy = 1'b0;
        t_dout       = dout;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            cs = 1'b0;
            if (k == 1) t_first_busy = busy;
            if (drdy === 1'b1) begin
                t_drdy_cnt++;
                t_drdy_idx = k;
                t_dout     = dout;
            end
            if (busy === 1'b0) begin
                t_busy_fall = k;
                break;
            end
            if (k == 1 && n >= 1)      din = o1;
            else if (k == 2 && n >= 2) din = o2;
            else                       din = 8'h00;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cs  = 1'b0;
        din = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h want=0", busy); end
        checks++; if (drdy !== 1'b0) begin failures++; $display("FAIL reset_drdy got=%0h want=0", drdy); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%0h want=00", dout); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tx_only;
        run_txn(8'h10, 0, 8'h00, 8'h00);
        checks++; if (t_first_busy !== 1'b1) begin failures++; $display("FAIL tx_busy_rise got=%0h want=1", t_first_busy); end
        checks++; if (t_drdy_cnt != 1) begin failures++; $display("FAIL tx_drdy_count got=%0d want=1", t_drdy_cnt); end
        checks++; if (t_drdy_idx != 2) begin failures++; $display("FAIL tx_drdy_latency got=%0d want=2", t_drdy_idx); end
        checks++; if (t_dout !== 8'h00) begin failures++; $display("FAIL tx_dout got=%0h want=00", t_dout); end
        checks++; if (t_busy_fall != 3) begin failures++; $display("FAIL tx_busy_fall got=%0d want=3", t_busy_fall); end
    endtask

    task automatic test_accumulate;
        run_txn(8'h07, 2, 8'h12, 8'h34);
        checks++; if (t_drdy_cnt != 0) begin failures++; $display("FAIL acc_no_drdy got=%0d want=0", t_drdy_cnt); end
        checks++; if (t_busy_fall != 4) begin failures++; $display("FAIL acc_busy_fall got=%0d want=4", t_busy_fall); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL acc_dout_held got=%0h want=00", dout); end
        run_txn(8'h19, 1, 8'h10, 8'h00);
        checks++; if (t_drdy_cnt != 1) begin failures++; $display("FAIL addres_drdy_count got=%0d want=1", t_drdy_cnt); end
        checks++; if (t_drdy_idx != 3) begin failures++; $display("FAIL addres_drdy_latency got=%0d want=3", t_drdy_idx); end
        checks++; if (t_dout !== 8'h56) begin failures++; $display("FAIL addres_dout got=%0h want=56", t_dout); end
        checks++; if (t_busy_fall != 4) begin failures++; $display("FAIL addres_busy_fall got=%0d want=4", t_busy_fall); end
    endtask

    task automatic test_overflow_clear;
        run_txn(8'h17, 2, 8'hF0, 8'h20);
        checks++; if (t_dout !== 8'h10) begin failures++; $display("FAIL overflow_dout got=%0h want=10", t_dout); end
        checks++; if (t_drdy_idx != 4) begin failures++; $display("FAIL overflow_drdy_latency got=%0d want=4", t_drdy_idx); end
        checks++; if (t_busy_fall != 5) begin failures++; $display("FAIL overflow_busy_fall got=%0d want=5", t_busy_fall); end
        run_txn(8'h39, 1, 8'h05, 8'h00);
        checks++; if (t_dout !== 8'h05) begin failures++; $display("FAIL clear_dout got=%0h want=05", t_dout); end
        checks++; if (t_drdy_cnt != 1) begin failures++; $display("FAIL clear_drdy_count got=%0d want=1", t_drdy_cnt); end
    endtask

    task automatic test_priority;
        run_txn(8'h1F, 2, 8'h01, 8'h02);
        checks++; if (t_dout !== 8'h03) begin failures++; $display("FAIL priority_dout got=%0h want=03", t_dout); end
    endtask

    task automatic test_null_cmd;
        run_txn(8'h00, 0, 8'h00, 8'h00);
        checks++; if (t_busy_fall != 2) begin failures++; $display("FAIL cmd0_busy_fall got=%0d want=2", t_busy_fall); end
        checks++; if (t_drdy_cnt != 0) begin failures++; $display("FAIL cmd0_drdy got=%0d want=0", t_drdy_cnt); end
        run_txn(8'hC0, 0, 8'h00, 8'h00);
        checks++; if (t_busy_fall != 2) begin failures++; $display("FAIL reserved_busy_fall got=%0d want=2", t_busy_fall); end
        run_txn(8'h10, 0, 8'h00, 8'h00);
        checks++; if (t_dout !== 8'h03) begin failures++; $display("FAIL null_result_kept got=%0h want=03", t_dout); end
    endtask

    task automatic test_back_to_back;
        int pulses;
        int busy_late;
        pulses    = 0;
        busy_late = 0;
        @(negedge clk);
        cs  = 1'b1;
        din = 8'h10;
        // Hold cs high through EXEC and TX; those samples must be dropped.
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k >= 3) cs = 1'b0;
            if (drdy === 1'b1) pulses++;
            if (k >= 3 && busy !== 1'b0) busy_late++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL busy_drop_drdy got=%0d want=1", pulses); end
        checks++; if (busy_late != 0) begin failures++; $display("FAIL busy_drop_extra_txn got=%0d want=0", busy_late); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        cs  = 1'b1;
        din = 8'h17;
        @(negedge clk);
        cs  = 1'b0;
        din = 8'hAA;
        @(negedge clk);
        din = 8'h55;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%0h want=1", busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0h want=0", busy); end
        checks++; if (drdy !== 1'b0) begin failures++; $display("FAIL midrst_drdy got=%0h want=0", drdy); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL midrst_dout got=%0h want=00", dout); end
        @(negedge clk);
        rst = 1'b1;
        din = 8'h00;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%0h want=0", busy); end
        run_txn(8'h10, 0, 8'h00, 8'h00);
        checks++; if (t_dout !== 8'h00) begin failures++; $display("FAIL midrst_result got=%0h want=00", t_dout); end
        checks++; if (t_drdy_cnt != 1) begin failures++; $display("FAIL midrst_drdy_count got=%0d want=1", t_drdy_cnt); end
    endtask

    initial begin
        rst = 1'b0;
        cs  = 1'b0;
        din = 8'h00;
        test_reset();
        test_tx_only();
        test_accumulate();
        test_overflow_clear();
        test_priority();
        test_null_cmd();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
